pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised inter-stage pipeline register. Successor to the fixed-field stage registers (e.g. M2W).
- Carries a generic payload plus a control field, using a valid/ready handshake with stall and flush.
- Has an optional 2-entry skid buffer, so no combinational ready path crosses the stage.
- Used between any two pipeline stages of the RISC-V core; control bits are guaranteed zero on bubbles, so RegWrite/MemWrite never fire spuriously.

Parameters:
- DATA_W, 32, payload width (operands, PC, immediate, concatenated by the instantiating stage).
- CTRL_W, 4, control-field width (RegWrite, ResultSrc, ...); forced to zero whenever the output is not valid.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- Flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control field; 0 when out_valid=0.
- out_data  out  DATA_W  payload of the head entry; holds its last value when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high; everything updates on the rising edge of CLK.
- Reset (RST=1 at a rising edge): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid entry cleared.
  - in_ready=1 in the cycle after reset when SKID=1.
  - RST has priority over Flush and all handshakes.
- Transfer definitions:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Latency: an accepted entry appears on out_* on the next cycle (1-cycle latency), ordering strictly FIFO.
- SKID=1 state machine (state = occupancy):
  - EMPTY(0): in_ready=1. Input transfer -> ONE, head loads input.
  - ONE(1): in_ready=1.
    - In and out transfer together: stay ONE, head loads input.
    - Out transfer only: -> EMPTY.
    - In transfer only: -> TWO, skid loads input.
    - Neither: hold.
  - TWO(2): in_ready=0.
    - Out transfer: -> ONE, head loads skid.
    - Otherwise hold.
  - in_ready is a registered function of state only (1 in EMPTY/ONE, 0 in TWO); no combinational path from out_ready.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Head loads on every input transfer.
  - Out transfer without input transfer clears out_valid.
- Stall: out_ready=0 holds head data and ctrl stable; out_data/out_ctrl must not change while out_valid=1 && out_ready=0.
- Flush=1 (and RST=0) at a rising edge:
  - occupancy -> 0, out_valid -> 0, out_ctrl -> 0, skid entry discarded.
  - An input presented in the same cycle is dropped even if in_ready=1; the upstream sees it as taken.
  - out_data keeps its value.
  - If an output transfer coincides with Flush, that output transfer completes normally; only held/incoming entries are killed.
- Bubble rule: out_ctrl = out_valid ? head_ctrl : 0, at all times including after flush and reset.
- Width rules:
  - Payload and control are stored unmodified; no arithmetic.
  - occupancy is 2 bits and never exceeds 2 (1 when SKID=0); no wrap-around.
- in_valid with in_ready=0: no state change; upstream must hold its data (AXI-style rule; checked by assertion on the upstream side, not here).

Test Plan:
- Reset mid-stream: SKID=1, fill with data 0x11, 0x22 (occupancy=2), assert RST one cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 every cycle, data 1,2,3,...,8 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first input; occupancy stays 1; in_ready never drops.
- Skid fill and drain: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held stable. Raise out_ready -> 0xA then 0xB emitted in order; in_ready=1 one cycle after the first pop.
- Flush with full skid: occupancy=2, ctrl=4'hF, Flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xC never appears at the output.
- Flush coinciding with output transfer: occupancy=1, out_ready=1, Flush=1 -> head consumed downstream that cycle, then out_valid=0. RST and Flush together -> reset values, including out_data=0.
- SKID=0 build: out_ready=0 with valid head -> in_ready=0 combinationally. Same cycle out_ready=1 -> in_ready=1, and the new entry replaces the head after 1 cycle with occupancy=1.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register: payload + control with stall, flush and
// an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [1:0]        occ_q, occ_d;
  logic              rdy_q, rdy_d;
  logic              in_xfer, out_xfer;

  assign out_valid = (occ_q != 2'd0);
  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign out_data  = head_data_q;
  assign occupancy = occ_q;
  // Skid mode exposes only the registered ready; single-register mode must look through.
  assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    occ_d       = occ_q;
    if (Flush) begin
      occ_d = 2'd0;
    end else begin
      case (occ_q)
        2'd0: if (in_xfer) begin
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
          occ_d       = 2'd1;
        end
        2'd1: begin
          if (in_xfer && out_xfer) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
          end else if (out_xfer) begin
            occ_d = 2'd0;
          end else if (in_xfer) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            occ_d       = 2'd2;
          end
        end
        2'd2: if (out_xfer) begin
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
          occ_d       = 2'd1;
        end
        default: occ_d = 2'd0;
      endcase
    end
    rdy_d = (occ_d != 2'd2);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      occ_q       <= 2'd0;
      rdy_q       <= 1'b1;
    end else begin
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      occ_q       <= occ_d;
      rdy_q       <= rdy_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Drives SKID=1 and SKID=0 stages with shared stimulus and checks both
// against queue-based models of a 2-deep and 1-deep FIFO stage.
module tb_pipe_stage_hs;
  logic        CLK = 1'b0;
  logic        RST, Flush, in_valid, out_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_data;
  logic        ir1, ov1, ir0, ov0;
  logic [3:0]  oc1, oc0;
  logic [31:0] od1, od0;
  logic [1:0]  occ1, occ0;
  logic [39:0] obs1, obs0;

  logic [35:0] q1[$];
  logic [35:0] q0[$];
  logic [31:0] last1, last0;
  int chk = 0, pass = 0;

  always #5 CLK = ~CLK;

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .SKID(1)) dut (
    .CLK(CLK), .RST(RST), .Flush(Flush), .in_valid(in_valid), .in_ready(ir1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1), .occupancy(occ1));

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(4), .SKID(0)) dut0 (
    .CLK(CLK), .RST(RST), .Flush(Flush), .in_valid(in_valid), .in_ready(ir0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_ctrl(oc0), .out_data(od0), .occupancy(occ0));

  assign obs1 = {ir1, ov1, oc1, od1, occ1};
  assign obs0 = {ir0, ov0, oc0, od0, occ0};

  // Expected {in_ready, out_valid, out_ctrl, out_data, occupancy} from the FIFO model.
  function automatic logic [39:0] exp_of(input bit skid);
    logic [35:0] h;
    logic [31:0] l;
    int n;
    logic v, r;
    if (skid) begin
      n = q1.size(); h = (n > 0) ? q1[0] : 36'h0; l = last1; r = (n < 2);
    end else begin
      n = q0.size(); h = (n > 0) ? q0[0] : 36'h0; l = last0; r = (n == 0) || out_ready;
    end
    v = (n > 0);
    return {r, v, v ? h[35:32] : 4'h0, v ? h[31:0] : l, n[1:0]};
  endfunction

  task automatic step();
    bit ix1, ox1, ix0, ox0;
    ix1 = in_valid && (q1.size() < 2);
    ox1 = (q1.size() > 0) && out_ready;
    ix0 = in_valid && ((q0.size() == 0) || out_ready);
    ox0 = (q0.size() > 0) && out_ready;
    @(posedge CLK);
    if (RST) begin
      q1.delete(); q0.delete(); last1 = 0; last0 = 0;
    end else begin
      if (ox1) void'(q1.pop_front());
      if (ox0) void'(q0.pop_front());
      if (Flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (ix1) q1.push_back({in_ctrl, in_data});
        if (ix0) q0.push_back({in_ctrl, in_data});
      end
      if (q1.size() > 0) last1 = q1[0][31:0];
      if (q0.size() > 0) last0 = q0[0][31:0];
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1; Flush = 0; in_valid = 0; out_ready = 0; in_ctrl = 0; in_data = 0;
    step();
    RST = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk++; if ({ov1, oc1, od1, occ1} !== 38'h0 || ir1 !== 1'b1)
      $display("FAIL reset_state got ir=%b ov=%b ctrl=%h data=%h occ=%0d want 1/0/0/0/0", ir1, ov1, oc1, od1, occ1);
    else pass++;
    chk++; if (obs0 !== exp_of(0)) $display("FAIL reset_skid0 got %h want %h", obs0, exp_of(0)); else pass++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1; in_data = 32'h11; in_ctrl = 4'h3; step();
    in_data = 32'h22; step();
    in_valid = 0; #1;
    chk++; if (occ1 !== 2'd2 || od1 !== 32'h11) $display("FAIL midstream_fill got occ=%0d data=%h want 2/11", occ1, od1); else pass++;
    RST = 1; step(); RST = 0; #1;
    chk++; if ({ov1, oc1, od1, occ1} !== 38'h0 || ir1 !== 1'b1)
      $display("FAIL midstream_reset got ir=%b ov=%b ctrl=%h data=%h occ=%0d want 1/0/0/0/0", ir1, ov1, oc1, od1, occ1);
    else pass++;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1; in_data = k; in_ctrl = k[3:0]; #1;
      if (k > 1) begin
        chk++; if (od1 !== k - 1 || occ1 !== 2'd1 || ir1 !== 1'b1 || ov1 !== 1'b1)
          $display("FAIL stream_%0d got data=%h occ=%0d ir=%b want %h/1/1", k, od1, occ1, ir1, k - 1);
        else pass++;
        chk++; if (obs0 !== exp_of(0)) $display("FAIL stream0_%0d got %h want %h", k, obs0, exp_of(0)); else pass++;
      end
      step();
    end
    in_valid = 0; #1;
    chk++; if (od1 !== 32'd8 || oc1 !== 4'd8) $display("FAIL stream_last got %h want 8", od1); else pass++;
    step();
  endtask

  task automatic test_skid_fill_drain();
    do_reset();
    in_valid = 1; in_data = 32'hA; in_ctrl = 4'h1; step();
    in_data = 32'hB; in_ctrl = 4'h2; step();
    in_valid = 0; #1;
    chk++; if (occ1 !== 2'd2 || ir1 !== 1'b0 || od1 !== 32'hA || oc1 !== 4'h1)
      $display("FAIL skid_full got occ=%0d ir=%b data=%h want 2/0/a", occ1, ir1, od1);
    else pass++;
    step(); #1;
    chk++; if (od1 !== 32'hA || oc1 !== 4'h1) $display("FAIL skid_stall got %h want a", od1); else pass++;
    out_ready = 1; step(); #1;
    chk++; if (od1 !== 32'hB || oc1 !== 4'h2 || ir1 !== 1'b1 || occ1 !== 2'd1)
      $display("FAIL skid_pop1 got data=%h ir=%b occ=%0d want b/1/1", od1, ir1, occ1);
    else pass++;
    step(); #1;
    chk++; if (ov1 !== 1'b0 || oc1 !== 4'h0 || od1 !== 32'hB) $display("FAIL skid_empty got ov=%b data=%h want 0/b", ov1, od1); else pass++;
  endtask

  task automatic test_flush_full();
    do_reset();
    in_valid = 1; in_ctrl = 4'hF; in_data = 32'hA; step();
    in_data = 32'hB; step();
    Flush = 1; in_data = 32'hC; step();
    Flush = 0; in_valid = 0; #1;
    chk++; if (ov1 !== 1'b0 || oc1 !== 4'h0 || occ1 !== 2'd0 || ir1 !== 1'b1)
      $display("FAIL flush_full got ov=%b ctrl=%h occ=%0d ir=%b want 0/0/0/1", ov1, oc1, occ1, ir1);
    else pass++;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk++; if (ov1 !== 1'b0 || od1 !== 32'hA) $display("FAIL flush_drop_%0d got ov=%b data=%h want 0/a", i, ov1, od1); else pass++;
    end
  endtask

  task automatic test_flush_out();
    do_reset();
    in_valid = 1; in_ctrl = 4'h6; in_data = 32'h5; step();
    in_valid = 0; out_ready = 1; Flush = 1; #1;
    chk++; if (ov1 !== 1'b1 || od1 !== 32'h5 || oc1 !== 4'h6) $display("FAIL flushout_pre got ov=%b data=%h want 1/5", ov1, od1); else pass++;
    step(); Flush = 0; #1;
    chk++; if (ov1 !== 1'b0 || occ1 !== 2'd0 || od1 !== 32'h5 || oc1 !== 4'h0)
      $display("FAIL flushout_post got ov=%b occ=%0d data=%h want 0/0/5", ov1, occ1, od1);
    else pass++;
    in_valid = 1; in_data = 32'h77; step();
    RST = 1; Flush = 1; step(); RST = 0; Flush = 0; in_valid = 0; #1;
    chk++; if ({ov1, oc1, od1, occ1} !== 38'h0 || ir1 !== 1'b1 || od0 !== 32'h0)
      $display("FAIL rst_flush got ov=%b data=%h occ=%0d d0=%h want all 0", ov1, od1, occ1, od0);
    else pass++;
  endtask

  task automatic test_skid0();
    do_reset();
    in_valid = 1; in_ctrl = 4'h9; in_data = 32'h31; step();
    in_data = 32'h32; in_ctrl = 4'hA; out_ready = 0; #1;
    chk++; if (ir0 !== 1'b0 || ov0 !== 1'b1 || od0 !== 32'h31) $display("FAIL skid0_stall got ir=%b data=%h want 0/31", ir0, od0); else pass++;
    out_ready = 1; #1;
    chk++; if (ir0 !== 1'b1) $display("FAIL skid0_ready got %b want 1", ir0); else pass++;
    step(); in_valid = 0; #1;
    chk++; if (od0 !== 32'h32 || oc0 !== 4'hA || occ0 !== 2'd1 || ov0 !== 1'b1)
      $display("FAIL skid0_replace got data=%h occ=%0d want 32/1", od0, occ0);
    else pass++;
  endtask

  task automatic test_random();
    int bad1 = 0, bad0 = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      RST       = ($urandom_range(0, 49) == 0);
      Flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_ctrl   = 4'($urandom);
      in_data   = $urandom;
      #1;
      if (obs1 !== exp_of(1)) begin
        if (bad1 < 5) $display("FAIL rand1 cyc=%0d got %h want %h", i, obs1, exp_of(1));
        bad1++;
      end
      if (obs0 !== exp_of(0)) begin
        if (bad0 < 5) $display("FAIL rand0 cyc=%0d got %h want %h", i, obs0, exp_of(0));
        bad0++;
      end
      step();
    end
    chk++; if (bad1 != 0) $display("FAIL rand_skid1 got %0d bad cycles want 0", bad1); else pass++;
    chk++; if (bad0 != 0) $display("FAIL rand_skid0 got %0d bad cycles want 0", bad0); else pass++;
  endtask

  initial begin
    last1 = 0; last0 = 0;
    test_reset();
    test_reset_midstream();
    test_streaming();
    test_skid_fill_drain();
    test_flush_full();
    test_flush_out();
    test_skid0();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
